led_pattern_gen: RTL and testbench

//   Parametrised multi-channel LED driver; next generation of the free-running blinker.

---
 rtl/led_pattern_gen.sv | 170 +++++++++++++++++
 tb/tb_led_pattern_gen.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// Multi-channel LED driver: each channel runs OFF, ON, BLINK or PWM from its own divider.
// Channel configuration is loaded through a two-cycle capture/apply write handshake.
module led_pattern_gen #(
    parameter int N_CH     = 4,
    parameter int PERIOD_W = 26,
    parameter int DUTY_W   = 8,
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cfg_we_i,
    input  logic [CH_W-1:0]     cfg_ch_i,
    input  logic [1:0]          cfg_mode_i,
    input  logic [PERIOD_W-1:0] cfg_period_i,
    input  logic [DUTY_W-1:0]   cfg_duty_i,
    output logic                cfg_ready_o,
    output logic [N_CH-1:0]     led_o
);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PWM   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        HS_INIT  = 2'd0,
        HS_IDLE  = 2'd1,
        HS_APPLY = 2'd2
    } hs_e;

    hs_e                 hs_q, hs_d;
    logic                capture;
    logic                apply;
    logic                ready_q;
    logic [CH_W-1:0]     pend_ch_q;
    mode_e               pend_mode_q;
    logic [PERIOD_W-1:0] pend_period_q;
    logic [DUTY_W-1:0]   pend_duty_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hs_q    <= HS_INIT;
            ready_q <= 1'b0;
        end else begin
            hs_q    <= hs_d;
            ready_q <= (hs_d == HS_IDLE);
        end
    end

    always_comb begin
        hs_d    = hs_q;
        capture = 1'b0;
        case (hs_q)
            HS_INIT:  hs_d = HS_IDLE;
            HS_IDLE: begin
                if (cfg_we_i) begin
                    capture = 1'b1;
                    hs_d    = HS_APPLY;
                end
            end
            HS_APPLY: hs_d = HS_IDLE;
            default:  hs_d = HS_INIT;
        endcase
    end

    assign apply       = (hs_q == HS_APPLY);
    assign cfg_ready_o = ready_q;

    // Captured write is held for exactly one cycle until the apply edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_ch_q     <= '0;
            pend_mode_q   <= MODE_OFF;
            pend_period_q <= '0;
            pend_duty_q   <= '0;
        end else if (capture) begin
            pend_ch_q     <= cfg_ch_i;
            pend_mode_q   <= mode_e'(cfg_mode_i);
            pend_period_q <= cfg_period_i;
            pend_duty_q   <= cfg_duty_i;
        end
    end

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        mode_e               mode_q, mode_d;
        logic [PERIOD_W-1:0] period_q, period_d;
        logic [PERIOD_W-1:0] cnt_q, cnt_d;
        logic [DUTY_W-1:0]   duty_q, duty_d;
        logic [DUTY_W-1:0]   phase_q, phase_d;
        logic                led_q, led_d;
        logic                hit;
        logic                tick;

        // Out-of-range channel indices never match, so such writes change nothing.
        assign hit  = apply && (pend_ch_q == CH_W'(gi));
        assign tick = (cnt_q == period_q);

        always_comb begin
            mode_d   = mode_q;
            period_d = period_q;
            duty_d   = duty_q;
            cnt_d    = cnt_q;
            phase_d  = phase_q;
            led_d    = led_q;
            if (hit) begin
                mode_d   = pend_mode_q;
                period_d = pend_period_q;
                duty_d   = pend_duty_q;
                cnt_d    = '0;
                phase_d  = '0;
                case (pend_mode_q)
                    MODE_OFF:   led_d = 1'b0;
                    MODE_ON:    led_d = 1'b1;
                    MODE_BLINK: led_d = 1'b1;
                    MODE_PWM:   led_d = (pend_duty_q != '0);
                    default:    led_d = 1'b0;
                endcase
            end else begin
                case (mode_q)
                    MODE_OFF: begin
                        cnt_d   = '0;
                        phase_d = '0;
                        led_d   = 1'b0;
                    end
                    MODE_ON: begin
                        cnt_d   = '0;
                        phase_d = '0;
                        led_d   = 1'b1;
                    end
                    MODE_BLINK: begin
                        cnt_d = tick ? '0 : cnt_q + 1'b1;
                        led_d = tick ? ~led_q : led_q;
                    end
                    MODE_PWM: begin
                        cnt_d   = tick ? '0 : cnt_q + 1'b1;
                        phase_d = tick ? phase_q + 1'b1 : phase_q;
                        led_d   = (phase_d < duty_q);
                    end
                    default: begin
                        cnt_d = '0;
                        led_d = 1'b0;
                    end
                endcase
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                mode_q   <= MODE_OFF;
                period_q <= '1;
                duty_q   <= '0;
                cnt_q    <= '0;
                phase_q  <= '0;
                led_q    <= 1'b0;
            end else begin
                mode_q   <= mode_d;
                period_q <= period_d;
                duty_q   <= duty_d;
                cnt_q    <= cnt_d;
                phase_q  <= phase_d;
                led_q    <= led_d;
            end
        end

        assign led_o[gi] = led_q;
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen: a 4-channel and a 3-channel instance share stimulus
// and are compared every cycle against a slot-arithmetic reference model.
module tb_led_pattern_gen;

    localparam int PW = 26;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          we = 1'b0;
    logic [1:0]    ch = '0;
    logic [1:0]    mode = '0;
    logic [PW-1:0] per = '0;
    logic [DW-1:0] duty = '0;
    logic          rdy4, rdy3;
    logic [3:0]    led4;
    logic [2:0]    led3;

    always #5 clk = ~clk;

    led_pattern_gen #(.N_CH(4), .PERIOD_W(PW), .DUTY_W(DW)) dut4 (
        .clk_i(clk), .rst_i(rst), .cfg_we_i(we), .cfg_ch_i(ch), .cfg_mode_i(mode),
        .cfg_period_i(per), .cfg_duty_i(duty), .cfg_ready_o(rdy4), .led_o(led4)
    );

    led_pattern_gen #(.N_CH(3), .PERIOD_W(PW), .DUTY_W(DW)) dut3 (
        .clk_i(clk), .rst_i(rst), .cfg_we_i(we), .cfg_ch_i(ch), .cfg_mode_i(mode),
        .cfg_period_i(per), .cfg_duty_i(duty), .cfg_ready_o(rdy3), .led_o(led3)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: index 0 mirrors the 4-channel instance, index 1 the 3-channel one.
    int     m_nch [2];
    bit     m_ready [2];
    bit     m_pend [2];
    int     m_pch [2];
    int     m_pmode [2];
    longint m_pper [2];
    int     m_pduty [2];
    int     m_mode [2][4];
    longint m_per [2][4];
    int     m_duty [2][4];
    longint m_n [2][4];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ready[k] = 1'b0;
            m_pend[k]  = 1'b0;
            for (int i = 0; i < 4; i++) begin
                m_mode[k][i] = 0;
                m_per[k][i]  = (longint'(1) << PW) - 1;
                m_duty[k][i] = 0;
                m_n[k][i]    = 0;
            end
        end
    endtask

    task automatic model_step(input int k, input bit s_we, input int s_ch, input int s_mode,
                              input longint s_per, input int s_duty);
        for (int i = 0; i < 4; i++) m_n[k][i]++;
        if (m_pend[k]) begin
            if (m_pch[k] < m_nch[k]) begin
                m_mode[k][m_pch[k]] = m_pmode[k];
                m_per[k][m_pch[k]]  = m_pper[k];
                m_duty[k][m_pch[k]] = m_pduty[k];
                m_n[k][m_pch[k]]    = 0;
            end
            m_pend[k]  = 1'b0;
            m_ready[k] = 1'b1;
        end else if (s_we && m_ready[k]) begin
            m_pch[k]   = s_ch;
            m_pmode[k] = s_mode;
            m_pper[k]  = s_per;
            m_pduty[k] = s_duty;
            m_pend[k]  = 1'b1;
            m_ready[k] = 1'b0;
        end else begin
            m_ready[k] = 1'b1;
        end
    endtask

    // LED level n edges after apply: slot = n/(P+1) divider ticks have elapsed.
    function automatic bit exp_led(input int k, input int i);
        longint slot;
        slot = m_n[k][i] / (m_per[k][i] + 1);
        case (m_mode[k][i])
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return (slot % 2) == 0;
            default: return (slot % 256) < m_duty[k][i];
        endcase
    endfunction

    task automatic check_all();
        logic [3:0] e4;
        logic [2:0] e3;
        for (int i = 0; i < 4; i++) e4[i] = exp_led(0, i);
        for (int i = 0; i < 3; i++) e3[i] = exp_led(1, i);
        check("ready4", rdy4, m_ready[0]);
        check("led4", led4, e4);
        check("ready3", rdy3, m_ready[1]);
        check("led3", led3, e3);
    endtask

    task automatic cycle();
        bit s_we; int s_ch, s_mode, s_duty; longint s_per;
        s_we = we; s_ch = ch; s_mode = mode; s_per = per; s_duty = duty;
        @(posedge clk);
        #1;
        if (!rst) begin
            model_step(0, s_we, s_ch, s_mode, s_per, s_duty);
            model_step(1, s_we, s_ch, s_mode, s_per, s_duty);
        end
        check_all();
    endtask

    task automatic do_write(input int c, input int md, input longint p, input int d);
        int guard;
        guard = 0;
        while (!rdy4 && guard < 8) begin
            cycle();
            guard++;
        end
        check("ready_wait", rdy4, 1);
        we = 1'b1; ch = 2'(c); mode = 2'(md); per = PW'(p); duty = DW'(d);
        cycle();
        we = 1'b0;
        cycle();
    endtask

    task automatic pwm_count(input int d, input int exp_high);
        int cnt;
        do_write(0, 3, 0, d);
        cnt = int'(led4[0]);
        for (int c = 0; c < 255; c++) begin
            cycle();
            cnt += int'(led4[0]);
        end
        check($sformatf("pwm_high_d%0d", d), cnt, exp_high);
    endtask

    typedef struct {
        int     ch;
        int     mode;
        longint per;
        int     duty;
        int     gap;
        bit     exp_led;
    } wr_t;

    typedef struct {
        int     ch;
        int     mode;
        longint per;
        int     duty;
        bit     exp_ready;
    } hs_t;

    wr_t wr_vec [8];
    hs_t hs_vec [6];

    initial begin
        int accepts;

        wr_vec[0] = '{ch: 1, mode: 2, per: 3, duty: 0,   gap: 20, exp_led: 1'b1};
        wr_vec[1] = '{ch: 2, mode: 2, per: 1, duty: 0,   gap: 1,  exp_led: 1'b1};
        wr_vec[2] = '{ch: 2, mode: 2, per: 1, duty: 0,   gap: 5,  exp_led: 1'b1};
        wr_vec[3] = '{ch: 2, mode: 1, per: 7, duty: 0,   gap: 2,  exp_led: 1'b1};
        wr_vec[4] = '{ch: 2, mode: 0, per: 7, duty: 0,   gap: 2,  exp_led: 1'b0};
        wr_vec[5] = '{ch: 0, mode: 3, per: 2, duty: 100, gap: 30, exp_led: 1'b1};
        wr_vec[6] = '{ch: 3, mode: 2, per: 0, duty: 0,   gap: 6,  exp_led: 1'b1};
        wr_vec[7] = '{ch: 0, mode: 3, per: 0, duty: 0,   gap: 4,  exp_led: 1'b0};

        hs_vec[0] = '{ch: 0, mode: 1, per: 0, duty: 0,  exp_ready: 1'b1};
        hs_vec[1] = '{ch: 1, mode: 2, per: 2, duty: 0,  exp_ready: 1'b0};
        hs_vec[2] = '{ch: 2, mode: 3, per: 1, duty: 90, exp_ready: 1'b1};
        hs_vec[3] = '{ch: 3, mode: 1, per: 0, duty: 0,  exp_ready: 1'b0};
        hs_vec[4] = '{ch: 1, mode: 1, per: 5, duty: 0,  exp_ready: 1'b1};
        hs_vec[5] = '{ch: 2, mode: 0, per: 0, duty: 0,  exp_ready: 1'b0};

        m_nch[0] = 4;
        m_nch[1] = 3;
        model_reset();

        // Power-on reset, checked before any clock edge.
        #2;
        rst = 1'b1;
        #1;
        check("por_ready", rdy4, 0);
        check("por_led", led4, 0);
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
        check("por_ready_rise", rdy4, 1);
        check("por_led_after", led4, 0);

        // Write to a channel index beyond N_CH=3: only the 4-channel instance reacts.
        do_write(3, 1, 0, 0);
        check("n3_led_untouched", led3, 0);
        check("n4_led_ch3_on", led4, 4'b1000);
        check("n3_ready_back", rdy3, 1);

        for (int j = 0; j < 8; j++) begin
            do_write(wr_vec[j].ch, wr_vec[j].mode, wr_vec[j].per, wr_vec[j].duty);
            check($sformatf("wr%0d_apply_led", j), led4[wr_vec[j].ch], wr_vec[j].exp_led);
            for (int g = 0; g < wr_vec[j].gap; g++) cycle();
        end

        pwm_count(64, 64);
        pwm_count(0, 0);
        pwm_count(255, 255);

        // WE held high with changing data: only every other edge may accept.
        begin
            int guard;
            guard = 0;
            while (!rdy4 && guard < 8) begin
                cycle();
                guard++;
            end
        end
        accepts = 0;
        for (int j = 0; j < 6; j++) begin
            we = 1'b1; ch = 2'(hs_vec[j].ch); mode = 2'(hs_vec[j].mode);
            per = PW'(hs_vec[j].per); duty = DW'(hs_vec[j].duty);
            check($sformatf("hs%0d_ready", j), rdy4, hs_vec[j].exp_ready);
            if (rdy4) accepts++;
            cycle();
        end
        we = 1'b0;
        cycle();
        check("hs_accepts", accepts, 3);
        for (int g = 0; g < 10; g++) cycle();

        for (int r = 0; r < 400; r++) begin
            we   = 1'($urandom_range(0, 1));
            ch   = 2'($urandom_range(0, 3));
            mode = 2'($urandom_range(0, 3));
            per  = PW'($urandom_range(0, 4));
            duty = DW'($urandom_range(0, 255));
            cycle();
        end

        // Make sure channels are lit and a write is pending, then reset between edges.
        we = 1'b0;
        do_write(1, 1, 0, 0);
        we = 1'b1; ch = 2'd0; mode = 2'd1; per = '0; duty = '0;
        cycle();
        we = 1'b0;
        check("pre_reset_pending", rdy4, 0);
        rst = 1'b1;
        model_reset();
        #1;
        check("mid_rst_ready", rdy4, 0);
        check("mid_rst_led4", led4, 0);
        check("mid_rst_led3", led3, 0);
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
        check("post_rst_ready", rdy4, 1);
        check("post_rst_led", led4, 0);
        for (int g = 0; g < 4; g++) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
